// File: rtl/game_pkg.sv
// Shared game definitions: grid defaults, packed position layout and the
// RNG sampler FSM state encodings.
package game_pkg;

    localparam int unsigned GRID_W_DEF = 12;
    localparam int unsigned GRID_H_DEF = 10;
    localparam int unsigned POS_W      = 8;

    typedef struct packed {
        logic [3:0] y;
        logic [3:0] x;
    } pos_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_FIRE      = 3'd2,
        S_WAIT_LOW  = 3'd3,
        S_WAIT_HIGH = 3'd4,
        S_CHECK     = 3'd5,
        S_PUSH      = 3'd6
    } state_e;

    // Widened compare so a 16-wide/16-high grid accepts every nibble.
    function automatic logic in_grid(pos_t p, int unsigned w, int unsigned h);
        return ({1'b0, p.x} < 5'(w)) && ({1'b0, p.y} < 5'(h));
    endfunction

endpackage

// File: rtl/pos_fifo.sv
// Synchronous circular FIFO for accepted grid positions; head, valid, empty,
// full and count are all registered, head reads 0 while empty.
module pos_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [3:0]       count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, empty_q, full_q;
    logic             do_push, do_pop;

    always_comb begin
        do_pop  = pop_i && valid_q;
        do_push = push_i && (!full_q || do_pop);
        rd_d    = do_pop  ? rd_q + PTR_W'(1) : rd_q;
        wr_d    = do_push ? wr_q + PTR_W'(1) : wr_q;
        cnt_d   = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 4'd1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 4'd1;
        end
        // A slot written this cycle at the new read pointer becomes the head.
        if (cnt_d == 4'd0) begin
            head_d = '0;
        end else if (do_push && (wr_q == rd_d)) begin
            head_d = wdata_i;
        end else begin
            head_d = mem_q[rd_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            valid_q <= (cnt_d != 4'd0);
            empty_q <= (cnt_d == 4'd0);
            full_q  <= (cnt_d == 4'(DEPTH));
        end
    end

    assign head_o  = head_q;
    assign valid_o = valid_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/rng_sampler.sv
// RNG requester: triggers the generator, rejection-samples bytes onto the grid
// and queues positions. Define RNG_SAMPLER_DEDUP_EN to reject repeat pushes.
module rng_sampler
    import game_pkg::*;
#(
    parameter int unsigned GRID_W     = GRID_W_DEF,
    parameter int unsigned GRID_H     = GRID_H_DEF,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       rng_ready,
    input  logic [7:0] rng_num,
    output logic       rng_trigger,
    output logic       pos_valid,
    output logic [3:0] pos_x,
    output logic [3:0] pos_y,
    input  logic       pos_ack,
    output logic [3:0] fifo_count,
    output logic       timeout_err
);

    state_e     state_q;
    logic       trig_q;
    logic [3:0] tmo_q;
    logic [3:0] tmo_inc;
    logic       tmo_hit;
    pos_t       num_q;
    logic       err_q;
    logic       sample_ok;
    logic       fifo_push;
    logic       fifo_empty;
    logic       fifo_full;
    logic       pop_eff;
    pos_t       head;

`ifdef RNG_SAMPLER_DEDUP_EN
    pos_t       last_q;
`endif

    always_comb begin
        sample_ok = in_grid(num_q, GRID_W, GRID_H);
`ifdef RNG_SAMPLER_DEDUP_EN
        sample_ok = sample_ok && (num_q != last_q);
`endif
        tmo_inc   = tmo_q + 4'd1;
        tmo_hit   = (tmo_inc == 4'(TIMEOUT));
        pop_eff   = pos_ack && !fifo_empty;
        fifo_push = (state_q == S_PUSH);
    end

    // Request FSM; rng_trigger is registered and high only while in ARM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            trig_q  <= 1'b0;
            tmo_q   <= '0;
            num_q   <= '0;
            err_q   <= 1'b0;
`ifdef RNG_SAMPLER_DEDUP_EN
            last_q  <= 8'hFF;
`endif
        end else begin
            trig_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable && (!fifo_full || pop_eff)) begin
                        state_q <= S_ARM;
                        trig_q  <= 1'b1;
                    end
                end
                S_ARM: begin
                    state_q <= S_FIRE;
                end
                S_FIRE: begin
                    tmo_q   <= '0;
                    state_q <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (!rng_ready) begin
                        state_q <= S_WAIT_HIGH;
                    end else begin
                        tmo_q <= tmo_inc;
                        if (tmo_hit) begin
                            err_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    if (rng_ready) begin
                        num_q   <= pos_t'(rng_num);
                        state_q <= S_CHECK;
                    end else begin
                        tmo_q <= tmo_inc;
                        if (tmo_hit) begin
                            err_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_CHECK: begin
                    if (sample_ok) begin
                        state_q <= S_PUSH;
                    end else begin
                        state_q <= S_ARM;
                        trig_q  <= 1'b1;
                    end
                end
                S_PUSH: begin
`ifdef RNG_SAMPLER_DEDUP_EN
                    last_q  <= num_q;
`endif
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    pos_fifo #(
        .WIDTH (POS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (num_q),
        .pop_i   (pos_ack),
        .head_o  (head),
        .valid_o (pos_valid),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign rng_trigger = trig_q;
    assign pos_x       = head.x;
    assign pos_y       = head.y;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_rng_sampler.sv
// Self-checking bench for rng_sampler with a behavioural trigger/ready RNG model.
module tb_rng_sampler;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       rng_ready;
    logic [7:0] rng_num;
    logic       rng_trigger;
    logic       pos_valid;
    logic [3:0] pos_x;
    logic [3:0] pos_y;
    logic       pos_ack;
    logic [3:0] fifo_count;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] rng_q[$];
    int         trig_cnt = 0;
    logic       no_drop  = 1'b0;
    logic       trig_prev = 1'b0;
    logic       pend = 1'b0;
    logic       rise = 1'b0;

    rng_sampler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rng_ready   (rng_ready),
        .rng_num     (rng_num),
        .rng_trigger (rng_trigger),
        .pos_valid   (pos_valid),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .pos_ack     (pos_ack),
        .fifo_count  (fifo_count),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RNG model: one cycle after the trigger falls, ready drops for one cycle,
    // then rises together with the next queued byte.
    initial begin
        rng_ready = 1'b1;
        rng_num   = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pend = 1'b0;
                rise = 1'b0;
                rng_ready = 1'b1;
                trig_prev = 1'b0;
            end else begin
                if (rise) begin
                    rng_ready = 1'b1;
                    rng_num   = (rng_q.size() > 0) ? rng_q.pop_front() : 8'h00;
                    rise      = 1'b0;
                end
                if (pend) begin
                    rng_ready = 1'b0;
                    pend      = 1'b0;
                    rise      = 1'b1;
                end
                if (rng_trigger && !trig_prev) trig_cnt++;
                if (!rng_trigger && trig_prev && !no_drop) pend = 1'b1;
                trig_prev = rng_trigger;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        enable   = 1'b0;
        pos_ack  = 1'b0;
        no_drop  = 1'b0;
        rng_q.delete();
        cycles(2);
        trig_cnt = 0;
        rst_n    = 1'b1;
    endtask

    task automatic pulse_enable();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic pop_one();
        pos_ack = 1'b1;
        @(negedge clk);
        pos_ack = 1'b0;
    endtask

    typedef struct {
        logic [7:0] v0;
        logic [7:0] v1;
        logic [7:0] v2;
        int         n;
        int         ex;
        int         ey;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int t0;
        int t1;
        int exp_trig;
        rst_n   = 1'b0;
        enable  = 1'b0;
        pos_ack = 1'b0;

        vecs[0] = '{8'h35, 8'h00, 8'h00, 1, 5, 3};
        vecs[1] = '{8'hC3, 8'h2D, 8'h47, 3, 7, 4};
        vecs[2] = '{8'hBB, 8'h9B, 8'h00, 2, 11, 9};
        vecs[3] = '{8'h0C, 8'hA0, 8'h00, 3, 0, 0};
        vecs[4] = '{8'h5F, 8'h96, 8'h00, 2, 6, 9};

        do_reset();
        @(negedge clk);
        check("reset_valid", int'(pos_valid), 0);
        check("reset_x", int'(pos_x), 0);
        check("reset_y", int'(pos_y), 0);
        check("reset_count", int'(fifo_count), 0);
        check("reset_err", int'(timeout_err), 0);
        check("reset_trig", int'(rng_trigger), 0);

        // Single-request vectors with rejection retries
        for (int v = 0; v < 5; v++) begin
            do_reset();
            rng_q.push_back(vecs[v].v0);
            if (vecs[v].n > 1) rng_q.push_back(vecs[v].v1);
            if (vecs[v].n > 2) rng_q.push_back(vecs[v].v2);
            @(negedge clk);
            pulse_enable();
            t0 = -1;
            for (int i = 0; i < 100 && !pos_valid; i++) begin
                if (rng_trigger && t0 < 0) t0 = cyc;
                @(negedge clk);
            end
            t1 = cyc;
            check($sformatf("vec%0d_valid", v), int'(pos_valid), 1);
            check($sformatf("vec%0d_latency", v), t1 - t0, 6 + 5 * (vecs[v].n - 1));
            check($sformatf("vec%0d_x", v), int'(pos_x), vecs[v].ex);
            check($sformatf("vec%0d_y", v), int'(pos_y), vecs[v].ey);
            cycles(10);
            check($sformatf("vec%0d_count", v), int'(fifo_count), 1);
            check($sformatf("vec%0d_trigs", v), trig_cnt, vecs[v].n);
            pop_one();
            check($sformatf("vec%0d_empty", v), int'(pos_valid), 0);
            check($sformatf("vec%0d_empty_x", v), int'(pos_x), 0);
        end

        // FIFO saturation, refill after a single pop, pop order
        do_reset();
        rng_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        enable = 1'b1;
        cycles(60);
        check("sat_count", int'(fifo_count), 4);
        check("sat_trigs", trig_cnt, 4);
        check("sat_head_x", int'(pos_x), 1);
        pop_one();
        check("sat_pop_count", int'(fifo_count), 3);
        check("sat_pop_head", int'(pos_y), 2);
        cycles(12);
        check("sat_refill_count", int'(fifo_count), 4);
        check("sat_refill_trigs", trig_cnt, 5);
        enable = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("sat_order_x%0d", k), int'(pos_x), k);
            check($sformatf("sat_order_y%0d", k), int'(pos_y), k);
            pop_one();
        end
        check("sat_drained", int'(pos_valid), 0);

        // Handshake timeout: ready never drops
        do_reset();
        no_drop = 1'b1;
        @(negedge clk);
        pulse_enable();
        t0 = cyc;
        for (int i = 0; i < 40 && !timeout_err; i++) @(negedge clk);
        check("tmo_err", int'(timeout_err), 1);
        check("tmo_latency", cyc - t0, 17);
        pulse_enable();
        cycles(3);
        check("tmo_retrigger", trig_cnt, 2);
        cycles(20);
        check("tmo_sticky", int'(timeout_err), 1);
        do_reset();
        @(negedge clk);
        check("tmo_cleared", int'(timeout_err), 0);

        // Reset while waiting for ready to rise with two entries queued
        do_reset();
        rng_q = '{8'h11, 8'h22, 8'h33};
        enable = 1'b1;
        for (int i = 0; i < 100 && trig_cnt < 3; i++) @(negedge clk);
        check("mid_pre_count", int'(fifo_count), 2);
        cycles(3);
        rst_n  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check("mid_count", int'(fifo_count), 0);
        check("mid_valid", int'(pos_valid), 0);
        check("mid_trig", int'(rng_trigger), 0);
        rst_n = 1'b1;
        cycles(10);
        check("mid_idle_trigs", trig_cnt, 3);
        check("mid_idle_count", int'(fifo_count), 0);

        // Back-to-back identical samples
        do_reset();
        rng_q = '{8'h35, 8'h35, 8'h12};
        enable = 1'b1;
        for (int i = 0; i < 100 && fifo_count < 4'd2; i++) @(negedge clk);
        enable = 1'b0;
        cycles(15);
`ifdef RNG_SAMPLER_DEDUP_EN
        exp_trig = 3;
`else
        exp_trig = 2;
`endif
        check("dup_count", int'(fifo_count), 2);
        check("dup_trigs", trig_cnt, exp_trig);
        check("dup_first_x", int'(pos_x), 5);
        check("dup_first_y", int'(pos_y), 3);
        pop_one();
`ifdef RNG_SAMPLER_DEDUP_EN
        check("dup_second_x", int'(pos_x), 2);
        check("dup_second_y", int'(pos_y), 1);
`else
        check("dup_second_x", int'(pos_x), 5);
        check("dup_second_y", int'(pos_y), 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
